// File: rtl/param_serializer.sv
// Parallel-to-serial shifter with a one-word holding buffer so that back-to-back
// words leave the serial line with no idle gap between them.
module param_serializer #(
  parameter int   DATA_W    = 8,
  parameter bit   MSB_FIRST = 1'b0,
  parameter logic IDLE_LVL  = 1'b1
) (
  input  logic              clk_ps,
  input  logic              rst_ps,
  input  logic [DATA_W-1:0] p_data_ps,
  input  logic              load_ps,
  input  logic              ser_en_ps,
  input  logic              abort_ps,
  output logic              ready_ps,
  output logic              busy_ps,
  output logic              ser_data_ps,
  output logic              ser_done_ps
);

  localparam int               IDX_W    = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic              hold_full_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] hold_q;

  logic accept;
  logic tick_shift;
  logic last_tick;
  logic load_shift;
  logic load_from_hold;
  logic load_hold;

  // The shift register physically moves toward its output end, so the bit on
  // the line is always the one at the fixed head position.
  function automatic logic head_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  assign ready_ps       = ~hold_full_q & ~abort_ps;
  assign accept         = load_ps & ready_ps;
  assign tick_shift     = (state_q == S_SHIFT) & ser_en_ps & ~abort_ps;
  assign last_tick      = tick_shift & (idx_q == LAST_IDX);
  // A word accepted on the final tick of the current one goes straight into
  // the shifter, exactly as if it had been waiting in the holding register.
  assign load_shift     = accept & ((state_q == S_IDLE) | last_tick);
  assign load_from_hold = last_tick & hold_full_q;
  assign load_hold      = accept & (state_q == S_SHIFT) & ~last_tick;

  always_ff @(posedge clk_ps) begin
    if (load_shift) begin
      shift_q <= p_data_ps;
    end else if (load_from_hold) begin
      shift_q <= hold_q;
    end else if (tick_shift) begin
      shift_q <= advance(shift_q);
    end
    if (load_hold) begin
      hold_q <= p_data_ps;
    end
  end

  always_ff @(posedge clk_ps or posedge rst_ps) begin
    if (rst_ps) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      hold_full_q <= 1'b0;
      busy_ps     <= 1'b0;
      ser_done_ps <= 1'b0;
      ser_data_ps <= IDLE_LVL;
    end else begin
      ser_done_ps <= 1'b0;
      if (abort_ps) begin
        state_q     <= S_IDLE;
        idx_q       <= '0;
        hold_full_q <= 1'b0;
        busy_ps     <= 1'b0;
        ser_data_ps <= IDLE_LVL;
      end else begin
        if (load_hold) begin
          hold_full_q <= 1'b1;
        end else if (load_from_hold) begin
          hold_full_q <= 1'b0;
        end
        case (state_q)
          S_IDLE: begin
            if (ser_en_ps) begin
              ser_data_ps <= IDLE_LVL;
            end
            if (accept) begin
              state_q <= S_SHIFT;
              busy_ps <= 1'b1;
              idx_q   <= '0;
            end
          end
          S_SHIFT: begin
            if (tick_shift) begin
              ser_data_ps <= head_bit(shift_q);
              if (last_tick) begin
                ser_done_ps <= 1'b1;
                idx_q       <= '0;
                if (!load_from_hold && !accept) begin
                  state_q <= S_IDLE;
                  busy_ps <= 1'b0;
                end
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_ps <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_param_serializer.sv
// Bench for param_serializer: an LSB-first and an MSB-first instance share the
// same stimulus and are checked every cycle against a queue-based word model.
module tb_param_serializer;

  localparam int W = 8;

  logic         clk    = 1'b0;
  logic         rst    = 1'b0;
  logic [W-1:0] p_data = '0;
  logic         load   = 1'b0;
  logic         ser_en = 1'b0;
  logic         abort  = 1'b0;

  logic ready_l, busy_l, ser_l, done_l;
  logic ready_m, busy_m, ser_m, done_m;

  int checks = 0;
  int errors = 0;

  param_serializer #(.DATA_W(W), .MSB_FIRST(1'b0), .IDLE_LVL(1'b1)) dut_l (
    .clk_ps(clk), .rst_ps(rst), .p_data_ps(p_data), .load_ps(load),
    .ser_en_ps(ser_en), .abort_ps(abort), .ready_ps(ready_l),
    .busy_ps(busy_l), .ser_data_ps(ser_l), .ser_done_ps(done_l)
  );

  param_serializer #(.DATA_W(W), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0)) dut_m (
    .clk_ps(clk), .rst_ps(rst), .p_data_ps(p_data), .load_ps(load),
    .ser_en_ps(ser_en), .abort_ps(abort), .ready_ps(ready_m),
    .busy_ps(busy_m), .ser_data_ps(ser_m), .ser_done_ps(done_m)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_b(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b expected=%0b", nm, act, exp);
    end
  endtask

  task automatic chk_v(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Model: words[0] is the word on the line, words[1] the one waiting.
  logic [W-1:0] words[$];
  int           pos     = 0;
  logic         m_ser_l = 1'b1;
  logic         m_ser_m = 1'b0;
  logic         m_done  = 1'b0;
  logic         acc_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      words.delete();
      pos     = 0;
      m_ser_l = 1'b1;
      m_ser_m = 1'b0;
      m_done  = 1'b0;
    end else begin
      acc_m  = load && (words.size() < 2) && !abort;
      m_done = 1'b0;
      if (abort) begin
        words.delete();
        pos     = 0;
        m_ser_l = 1'b1;
        m_ser_m = 1'b0;
      end else begin
        if (ser_en) begin
          if (words.size() == 0) begin
            m_ser_l = 1'b1;
            m_ser_m = 1'b0;
          end else begin
            m_ser_l = words[0][pos];
            m_ser_m = words[0][W-1-pos];
            pos++;
            if (pos == W) begin
              void'(words.pop_front());
              pos    = 0;
              m_done = 1'b1;
            end
          end
        end
        if (acc_m) words.push_back(p_data);
      end
    end
  end

  logic [31:0] hist_l = '0;
  logic [31:0] hist_m = '0;
  logic [31:0] hist_d = '0;

  always @(posedge clk) begin
    #1;
    chk_b("ser_lsb",   ser_l,   m_ser_l);
    chk_b("ser_msb",   ser_m,   m_ser_m);
    chk_b("done_lsb",  done_l,  m_done);
    chk_b("done_msb",  done_m,  m_done);
    chk_b("busy_lsb",  busy_l,  words.size() != 0);
    chk_b("busy_msb",  busy_m,  words.size() != 0);
    chk_b("ready_lsb", ready_l, (words.size() < 2) && !abort);
    chk_b("ready_msb", ready_m, (words.size() < 2) && !abort);
    hist_l = {hist_l[30:0], ser_l};
    hist_m = {hist_m[30:0], ser_m};
    hist_d = {hist_d[30:0], done_l};
  end

  task automatic step(input logic ld, input logic [W-1:0] d, input logic en, input logic ab);
    @(negedge clk);
    load   = ld;
    p_data = d;
    ser_en = en;
    abort  = ab;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_b({tag, "_ser_l"},   ser_l,   1'b1);
    chk_b({tag, "_ser_m"},   ser_m,   1'b0);
    chk_b({tag, "_busy_l"},  busy_l,  1'b0);
    chk_b({tag, "_busy_m"},  busy_m,  1'b0);
    chk_b({tag, "_done_l"},  done_l,  1'b0);
    chk_b({tag, "_ready_l"}, ready_l, 1'b1);
    chk_b({tag, "_ready_m"}, ready_m, 1'b1);
  endtask

  int done_at;
  int busy_cnt;

  initial begin
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // 0xA5 LSB-first with a tick every cycle; input changes after accept
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    step(1'b0, 8'hFF, 1'b1, 1'b0);
    repeat (7) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_v("a5_bits_lsb", {24'd0, hist_l[7:0]}, 32'h0000_00A5);
    chk_v("a5_bits_msb", {24'd0, hist_m[7:0]}, 32'h0000_00A5);
    chk_v("a5_done",     {24'd0, hist_d[7:0]}, 32'h0000_0001);
    idle(1);
    chk_b("a5_idle_lvl", ser_l, 1'b1);
    chk_b("a5_busy_end", busy_l, 1'b0);
    idle(2);

    // back-to-back 0x3C, 0xC3 with extra loads while the buffer is full
    step(1'b1, 8'h3C, 1'b1, 1'b0);
    step(1'b1, 8'hC3, 1'b1, 1'b0);
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    chk_b("pair_ready_pend", ready_l, 1'b0);
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    repeat (13) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_v("pair_bits", {16'd0, hist_l[15:0]}, 32'h0000_3CC3);
    chk_v("pair_done", {16'd0, hist_d[15:0]}, 32'h0000_0101);
    idle(1);
    chk_b("pair_busy_end", busy_l, 1'b0);
    idle(2);

    // second word accepted on the last-bit tick of the first
    step(1'b1, 8'h0F, 1'b1, 1'b0);
    repeat (7) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'hF0, 1'b1, 1'b0);
    chk_b("lastacc_busy", busy_l, 1'b1);
    repeat (8) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_v("lastacc_bits_lsb", {16'd0, hist_l[15:0]}, 32'h0000_F00F);
    chk_v("lastacc_bits_msb", {16'd0, hist_m[15:0]}, 32'h0000_0FF0);
    chk_v("lastacc_done",     {16'd0, hist_d[15:0]}, 32'h0000_0101);
    idle(3);

    // 0x01 with one tick every fourth cycle
    done_at  = -1;
    busy_cnt = 0;
    for (int i = 0; i <= 32; i++) begin
      step(i == 0, 8'h01, (i > 0) && (i % 4 == 0), 1'b0);
      if (done_l) done_at = i;
      if (busy_l) busy_cnt++;
    end
    chk_v("slow_done_at",  done_at,  32'd32);
    chk_v("slow_busy_cnt", busy_cnt, 32'd32);
    chk_v("slow_bits_lsb", hist_l, 32'hFE00_0000);
    chk_v("slow_bits_msb", hist_m, 32'h0000_0001);
    idle(2);

    // abort after three bits of 0xFF with 0x00 pending
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b1);
    chk_b("abort_ser_l",  ser_l,  1'b1);
    chk_b("abort_ser_m",  ser_m,  1'b0);
    chk_b("abort_busy",   busy_l, 1'b0);
    chk_b("abort_done",   done_l, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_b("abort_ready_after", ready_l, 1'b1);
    idle(9);
    chk_v("abort_no_done", {21'd0, hist_d[10:0]}, 32'd0);
    chk_v("abort_line",    {21'd0, hist_l[10:0]}, 32'h0000_07FF);
    chk_b("abort_busy_after", busy_l, 1'b0);

    // asynchronous reset mid-word, then a fresh word
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk_reset_outputs("arst");
    @(negedge clk) rst = 1'b0;
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    repeat (8) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_v("rst_5a_lsb",  {24'd0, hist_l[7:0]}, 32'h0000_005A);
    chk_v("rst_5a_msb",  {24'd0, hist_m[7:0]}, 32'h0000_005A);
    chk_v("rst_5a_done", {24'd0, hist_d[7:0]}, 32'h0000_0001);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
